// File: rtl/game_round_ctrl.sv
// Round sequencer for the symbol-counting game: launch, answer window, scoring.
// Optional streak bonus is selected by defining STREAK_BONUS_EN.
module game_round_ctrl #(
  parameter int unsigned NUM_ROUNDS  = 5,
  parameter int unsigned ANSWER_SECS = 10,
  parameter logic [31:0] BASE_MAX    = 32'd100_000_000,
  parameter logic [31:0] MAX_STEP    = 32'd10_000_000,
  parameter logic [31:0] MIN_MAX     = 32'd20_000_000
) (
  input  logic        Clk100M,
  input  logic        Rst_n,
  input  logic        tick1Hz,
  input  logic        startBtn,
  input  logic        periodDone,
  input  logic [7:0]  numSpecial,
  input  logic        answerValid,
  input  logic [7:0]  answerVal,
  output logic        gameSig,
  output logic [31:0] symGenMax,
  output logic [3:0]  round,
  output logic [7:0]  score,
  output logic        answerWindow,
  output logic        correctPulse,
  output logic        missPulse,
  output logic        gameOver
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, PLAY, ANSWER, SCORE, DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);
  localparam logic [7:0] SECS = 8'(ANSWER_SECS);

  state_t      state;
  logic [7:0]  expected;
  logic [7:0]  answerTimer;
  logic [7:0]  inc;
  logic [8:0]  scoreSum;
  logic [32:0] stepFloor;
  logic [31:0] nextMax;

`ifdef STREAK_BONUS_EN
  logic [1:0]  streak;
`endif

  always_comb begin
    inc = 8'd1;
`ifdef STREAK_BONUS_EN
    if (streak >= 2'd2) inc = 8'd2;
`endif
    scoreSum  = {1'b0, score} + {1'b0, inc};
    stepFloor = {1'b0, MIN_MAX} + {1'b0, MAX_STEP};
    // compare in 33 bits so the step never wraps below the floor
    if ({1'b0, symGenMax} >= stepFloor)
      nextMax = symGenMax - MAX_STEP;
    else
      nextMax = MIN_MAX;
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      gameSig      <= 1'b0;
      symGenMax    <= BASE_MAX;
      round        <= 4'd0;
      score        <= 8'd0;
      answerWindow <= 1'b0;
      correctPulse <= 1'b0;
      missPulse    <= 1'b0;
      gameOver     <= 1'b0;
      answerTimer  <= 8'd0;
      expected     <= 8'd0;
`ifdef STREAK_BONUS_EN
      streak       <= 2'd0;
`endif
    end else begin
      gameSig      <= 1'b0;
      correctPulse <= 1'b0;
      missPulse    <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (startBtn) begin
            round     <= 4'd0;
            score     <= 8'd0;
            symGenMax <= BASE_MAX;
            gameOver  <= 1'b0;
            gameSig   <= 1'b1;
`ifdef STREAK_BONUS_EN
            streak    <= 2'd0;
`endif
            state     <= LAUNCH;
          end
        end
        LAUNCH: state <= PLAY;
        PLAY: begin
          if (periodDone) begin
            expected     <= numSpecial;
            answerTimer  <= SECS;
            answerWindow <= 1'b1;
            state        <= ANSWER;
          end
        end
        ANSWER: begin
          // an answer beats a timeout landing in the same cycle
          if (answerValid) begin
            answerWindow <= 1'b0;
            correctPulse <= (answerVal == expected);
            missPulse    <= (answerVal != expected);
            state        <= SCORE;
          end else if (tick1Hz) begin
            answerTimer <= answerTimer - 8'd1;
            if (answerTimer == 8'd1) begin
              answerWindow <= 1'b0;
              missPulse    <= 1'b1;
              state        <= SCORE;
            end
          end
        end
        SCORE: begin
          if (correctPulse) begin
            score <= scoreSum[8] ? 8'hFF : scoreSum[7:0];
`ifdef STREAK_BONUS_EN
            if (streak != 2'd3) streak <= streak + 2'd1;
          end else begin
            streak <= 2'd0;
`endif
          end
          if (round == LAST) begin
            gameOver <= 1'b1;
            state    <= DONE;
          end else begin
            round     <= round + 4'd1;
            symGenMax <= nextMax;
            gameSig   <= 1'b1;
            state     <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: default instance plus a long-game
// instance (NUM_ROUNDS=12) that exposes the symGenMax floor.
module tb_game_round_ctrl;

  logic        Clk100M = 1'b0;
  logic        Rst_n;
  logic        tick1Hz = 1'b0;
  logic        startBtn = 1'b0;
  logic        periodDone = 1'b0;
  logic [7:0]  numSpecial = 8'd0;
  logic        answerValid = 1'b0;
  logic [7:0]  answerVal = 8'd0;

  logic        gameSig, answerWindow, correctPulse, missPulse, gameOver;
  logic [31:0] symGenMax;
  logic [3:0]  round;
  logic [7:0]  score;

  logic        fGameSig, fWindow, fCorrect, fMiss, fOver;
  logic [31:0] fSymGenMax;
  logic [3:0]  fRound;
  logic [7:0]  fScore;

  int total = 0;
  int passed = 0;

  always #5 Clk100M = ~Clk100M;

  game_round_ctrl dut (
    .Clk100M(Clk100M), .Rst_n(Rst_n), .tick1Hz(tick1Hz),
    .startBtn(startBtn), .periodDone(periodDone),
    .numSpecial(numSpecial), .answerValid(answerValid),
    .answerVal(answerVal), .gameSig(gameSig),
    .symGenMax(symGenMax), .round(round), .score(score),
    .answerWindow(answerWindow), .correctPulse(correctPulse),
    .missPulse(missPulse), .gameOver(gameOver)
  );

  game_round_ctrl #(.NUM_ROUNDS(12)) dut_f (
    .Clk100M(Clk100M), .Rst_n(Rst_n), .tick1Hz(tick1Hz),
    .startBtn(startBtn), .periodDone(periodDone),
    .numSpecial(numSpecial), .answerValid(answerValid),
    .answerVal(answerVal), .gameSig(fGameSig),
    .symGenMax(fSymGenMax), .round(fRound), .score(fScore),
    .answerWindow(fWindow), .correctPulse(fCorrect),
    .missPulse(fMiss), .gameOver(fOver)
  );

  task automatic step(input int n);
    repeat (n) @(posedge Clk100M);
    #1;
  endtask

  task automatic pulse_start();
    startBtn = 1'b1;
    step(1);
    startBtn = 1'b0;
  endtask

  task automatic pulse_period(input logic [7:0] n);
    numSpecial = n;
    periodDone = 1'b1;
    step(1);
    periodDone = 1'b0;
  endtask

  task automatic pulse_answer(input logic [7:0] v);
    answerVal = v;
    answerValid = 1'b1;
    step(1);
    answerValid = 1'b0;
  endtask

  task automatic pulse_tick();
    tick1Hz = 1'b1;
    step(1);
    tick1Hz = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    step(3);
    total++;
    if ({gameSig, answerWindow, correctPulse, missPulse, gameOver,
         round, score, symGenMax} !== {5'b0, 4'd0, 8'd0, 32'd100_000_000})
      $display("FAIL reset_state flags=%b round=%0d score=%0d max=%0d req 0/0/0/100000000",
               {gameSig, answerWindow, correctPulse, missPulse, gameOver},
               round, score, symGenMax);
    else passed++;
    Rst_n = 1'b1;
    step(3);
    total++;
    if ({gameSig, gameOver, answerWindow} !== 3'b000)
      $display("FAIL idle_no_start got=%b req 000",
               {gameSig, gameOver, answerWindow});
    else passed++;
  endtask

  task automatic test_basic();
    pulse_start();
    total++;
    if (gameSig !== 1'b1)
      $display("FAIL launch_gamesig got=%b req 1", gameSig);
    else passed++;
    step(1);
    total++;
    if (gameSig !== 1'b0)
      $display("FAIL gamesig_one_cycle got=%b req 0", gameSig);
    else passed++;
    pulse_answer(8'd3);
    pulse_start();
    total++;
    if ({answerWindow, correctPulse, missPulse, gameSig} !== 4'b0000)
      $display("FAIL ignore_in_play got=%b req 0000",
               {answerWindow, correctPulse, missPulse, gameSig});
    else passed++;
    pulse_period(8'd3);
    total++;
    if (answerWindow !== 1'b1)
      $display("FAIL answer_window got=%b req 1", answerWindow);
    else passed++;
    pulse_answer(8'd3);
    total++;
    if ({correctPulse, missPulse, answerWindow} !== 3'b100)
      $display("FAIL basic_verdict got=%b req 100",
               {correctPulse, missPulse, answerWindow});
    else passed++;
    step(1);
    total++;
    if ({score, round, symGenMax, gameSig, correctPulse} !==
        {8'd1, 4'd1, 32'd90_000_000, 2'b10})
      $display("FAIL basic_after score=%0d round=%0d max=%0d req 1/1/90000000",
               score, round, symGenMax);
    else passed++;
  endtask

  task automatic test_timeout();
    step(1);
    pulse_period(8'd5);
    for (int i = 0; i < 9; i++) begin
      pulse_tick();
      step(1);
    end
    total++;
    if ({missPulse, answerWindow} !== 2'b01)
      $display("FAIL timeout_9_ticks got=%b req 01", {missPulse, answerWindow});
    else passed++;
    pulse_tick();
    total++;
    if ({missPulse, correctPulse} !== 2'b10)
      $display("FAIL timeout_miss got=%b req 10", {missPulse, correctPulse});
    else passed++;
    step(1);
    total++;
    if ({score, round, symGenMax} !== {8'd1, 4'd2, 32'd80_000_000})
      $display("FAIL timeout_after score=%0d round=%0d max=%0d req 1/2/80000000",
               score, round, symGenMax);
    else passed++;
  endtask

  task automatic test_tie();
    step(1);
    pulse_period(8'd7);
    for (int i = 0; i < 9; i++) begin
      pulse_tick();
      step(1);
    end
    answerVal = 8'd7;
    answerValid = 1'b1;
    tick1Hz = 1'b1;
    step(1);
    answerValid = 1'b0;
    tick1Hz = 1'b0;
    total++;
    if ({correctPulse, missPulse} !== 2'b10)
      $display("FAIL tie_priority got=%b req 10", {correctPulse, missPulse});
    else passed++;
    step(1);
    total++;
    if ({score, round, symGenMax} !== {8'd2, 4'd3, 32'd70_000_000})
      $display("FAIL tie_after score=%0d round=%0d max=%0d req 2/3/70000000",
               score, round, symGenMax);
    else passed++;
  endtask

  task automatic test_wrong();
    step(1);
    pulse_period(8'd5);
    pulse_answer(8'd4);
    total++;
    if ({correctPulse, missPulse} !== 2'b01)
      $display("FAIL wrong_verdict got=%b req 01", {correctPulse, missPulse});
    else passed++;
    step(1);
    total++;
    if ({score, round, symGenMax} !== {8'd2, 4'd4, 32'd60_000_000})
      $display("FAIL wrong_after score=%0d round=%0d max=%0d req 2/4/60000000",
               score, round, symGenMax);
    else passed++;
  endtask

  task automatic test_game_over();
    step(1);
    pulse_period(8'd9);
    pulse_answer(8'd9);
    total++;
    if (correctPulse !== 1'b1)
      $display("FAIL last_verdict got=%b req 1", correctPulse);
    else passed++;
    step(1);
    total++;
    if ({gameOver, gameSig, score, round} !== {2'b10, 8'd3, 4'd4})
      $display("FAIL game_over over=%b sig=%b score=%0d round=%0d req 1/0/3/4",
               gameOver, gameSig, score, round);
    else passed++;
    total++;
    if ({fOver, fGameSig, fRound, fSymGenMax} !==
        {2'b01, 4'd5, 32'd50_000_000})
      $display("FAIL long_game_r5 over=%b round=%0d max=%0d req 0/5/50000000",
               fOver, fRound, fSymGenMax);
    else passed++;
  endtask

  task automatic test_floor();
    logic [31:0] expMax [4];
    expMax = '{32'd40_000_000, 32'd30_000_000,
               32'd20_000_000, 32'd20_000_000};
    for (int i = 0; i < 4; i++) begin
      step(1);
      pulse_period(8'd1);
      total++;
      if (answerWindow !== 1'b0)
        $display("FAIL done_ignores_period window=%b req 0", answerWindow);
      else passed++;
      pulse_answer(8'd0);
      step(1);
      total++;
      if ({fRound, fSymGenMax} !== {4'(6 + i), expMax[i]})
        $display("FAIL floor_round%0d round=%0d max=%0d req %0d/%0d",
                 i, fRound, fSymGenMax, 6 + i, expMax[i]);
      else passed++;
    end
    total++;
    if ({gameOver, score, round} !== {1'b1, 8'd3, 4'd4})
      $display("FAIL done_hold over=%b score=%0d round=%0d req 1/3/4",
               gameOver, score, round);
    else passed++;
  endtask

  task automatic test_restart();
    pulse_start();
    total++;
    if ({gameSig, gameOver, score, round, symGenMax} !==
        {2'b10, 8'd0, 4'd0, 32'd100_000_000})
      $display("FAIL restart sig=%b over=%b score=%0d round=%0d max=%0d req 1/0/0/0/100000000",
               gameSig, gameOver, score, round, symGenMax);
    else passed++;
    total++;
    if ({fRound, fScore, fGameSig} !== {4'd9, 8'd3, 1'b0})
      $display("FAIL launch_ignores_start round=%0d score=%0d sig=%b req 9/3/0",
               fRound, fScore, fGameSig);
    else passed++;
  endtask

  task automatic test_streak();
    logic [7:0] expScore [4];
`ifdef STREAK_BONUS_EN
    expScore = '{8'd1, 8'd2, 8'd4, 8'd6};
`else
    expScore = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
    for (int i = 0; i < 4; i++) begin
      step(1);
      pulse_period(8'(10 + i));
      pulse_answer(8'(10 + i));
      step(1);
      total++;
      if (score !== expScore[i])
        $display("FAIL streak_score%0d got=%0d req %0d", i, score, expScore[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    step(1);
    pulse_period(8'd2);
    total++;
    if (answerWindow !== 1'b1)
      $display("FAIL mid_window got=%b req 1", answerWindow);
    else passed++;
    Rst_n = 1'b0;
    #1;
    total++;
    if ({gameSig, answerWindow, correctPulse, missPulse, gameOver,
         round, score, symGenMax} !== {5'b0, 4'd0, 8'd0, 32'd100_000_000})
      $display("FAIL mid_reset flags=%b round=%0d score=%0d max=%0d req 0/0/0/100000000",
               {gameSig, answerWindow, correctPulse, missPulse, gameOver},
               round, score, symGenMax);
    else passed++;
    step(2);
    Rst_n = 1'b1;
    step(1);
    pulse_answer(8'd2);
    total++;
    if ({correctPulse, missPulse, answerWindow} !== 3'b000)
      $display("FAIL post_reset_answer got=%b req 000",
               {correctPulse, missPulse, answerWindow});
    else passed++;
    pulse_period(8'd2);
    step(3);
    total++;
    if ({answerWindow, gameSig, score} !== {2'b00, 8'd0})
      $display("FAIL post_reset_idle window=%b sig=%b score=%0d req 0/0/0",
               answerWindow, gameSig, score);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_tie();
    test_wrong();
    test_game_over();
    test_floor();
    test_restart();
    test_streak();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 5: rounds per game, legal range 1..15.
REQ-002 Parameter ANSWER_SECS, default 10: seconds allowed for an answer, legal range 1..255.
REQ-003 Parameter BASE_MAX, default 32'd100_000_000: symGenMax value for round 0.
REQ-004 Parameter MAX_STEP, default 32'd10_000_000: symGenMax decrement applied per round.
REQ-005 Parameter MIN_MAX, default 32'd20_000_000: floor for symGenMax.
REQ-006 Clk100M  in  1  system clock; one clock; all logic on its rising edge.
REQ-007 Rst_n  in  1  reset; asynchronous, active-low.
REQ-008 tick1Hz  in  1  one-cycle pulse once per second, synchronous to Clk100M.
REQ-009 startBtn  in  1  one-cycle pulse requesting a new game.
REQ-010 periodDone  in  1  one-cycle pulse marking the end of the symbol period (the period block's stopGen).
REQ-011 numSpecial  in  8  special-symbol count from the period block.
REQ-012 answerValid  in  1  one-cycle pulse qualifying answerVal.
REQ-013 answerVal  in  8  player's count.
REQ-014 gameSig  out  1  one-cycle pulse that starts a symbol period.
REQ-015 symGenMax  out  32  generator interval for the current round.
REQ-016 round  out  4  current round index, 0-based.
REQ-017 score  out  8  accumulated score, saturating.
REQ-018 answerWindow  out  1  high while the block accepts an answer.
REQ-019 correctPulse / missPulse  out  1 each  one-cycle verdict pulses.
REQ-020 gameOver  out  1  high in DONE.

Function
REQ-021 The FSM SHALL use the states IDLE, LAUNCH, PLAY, ANSWER, SCORE, DONE; all outputs SHALL be registered.
REQ-022 IDLE or DONE + startBtn SHALL load round=0, score=0, streak=0, symGenMax=BASE_MAX, then go to LAUNCH on the next cycle.
REQ-023 LAUNCH SHALL assert gameSig for exactly one cycle and go to PLAY.
REQ-024 PLAY + periodDone SHALL latch numSpecial into expected, load answerTimer=ANSWER_SECS, and go to ANSWER.
REQ-025 ANSWER SHALL hold answerWindow=1 and decrement answerTimer on each tick1Hz.
REQ-026 ANSWER + answerValid SHALL latch answerVal and go to SCORE (answered).
REQ-027 ANSWER with answerTimer==1 and tick1Hz SHALL go to SCORE (timeout).
REQ-028 answerValid SHALL take priority over timeout when both occur in the same cycle.
REQ-029 SCORE SHALL last one cycle and pulse correctPulse when answered and answerVal==expected, otherwise missPulse.
REQ-030 A correct answer SHALL add the increment from REQ-039/040 to score, saturating at 255; a miss SHALL clear streak and leave score unchanged.
REQ-031 SCORE with round==NUM_ROUNDS-1 SHALL go to DONE; otherwise it SHALL set round+1, set symGenMax=max(symGenMax-MAX_STEP, MIN_MAX) with no underflow wrap, and go to LAUNCH.
REQ-032 DONE SHALL hold gameOver=1 and keep score and round until startBtn.
REQ-033 startBtn in LAUNCH, PLAY, ANSWER or SCORE SHALL be ignored; answerValid outside ANSWER SHALL be ignored; periodDone outside PLAY SHALL be ignored.

Reset
REQ-034 Rst_n low SHALL immediately force IDLE, gameSig=0, symGenMax=BASE_MAX, round=0, score=0, streak=0, answerWindow=0, correctPulse=0, missPulse=0, gameOver=0, and answerTimer=0.
REQ-035 Reset mid-round SHALL abandon the round, with no verdict pulse emitted.
REQ-036 The first transition after reset release SHALL require a fresh startBtn.

Configuration
REQ-037 The macro STREAK_BONUS_EN SHALL select the streak bonus feature.
REQ-038 A 2-bit saturating streak counter SHALL increment on each correct answer.
REQ-039 With STREAK_BONUS_EN defined, a correct answer made while streak>=2 before the increment SHALL add 2 to score; any other correct answer SHALL add 1.
REQ-040 Without STREAK_BONUS_EN, every correct answer SHALL add 1 and the streak logic SHALL be absent.

Verification
REQ-041 Reset, startBtn, periodDone with numSpecial=3, then answerValid with answerVal=3 -> gameSig 1 cycle after start, correctPulse, score=1, round=1, symGenMax=90_000_000.
REQ-042 No answer and 10 tick1Hz pulses in ANSWER -> missPulse on the cycle after the 10th tick, score unchanged.
REQ-043 answerValid (correct) and the final tick1Hz in the same cycle -> correctPulse only.
REQ-044 9 rounds played -> symGenMax floors at 20_000_000; with NUM_ROUNDS=5, 5 rounds played -> gameOver=1, a further periodDone has no effect, startBtn restarts with score=0.
REQ-045 With STREAK_BONUS_EN, 4 consecutive correct answers -> score 1,2,4,6; without it -> 1,2,3,4.
REQ-046 Rst_n low during ANSWER -> all outputs at reset values in the same cycle, and answerValid after release is ignored.
